// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-master RAM arbiter:
// master ids, defaults, byte enables and bundles.
package mem_arbiter_pkg;

  localparam logic MID_CPU = 1'b0;
  localparam logic MID_DMA = 1'b1;

  localparam int RD_LATENCY_DEF = 1;
  localparam int MAX_BURST_DEF  = 4;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

  typedef struct packed {
    logic v;
    logic id;
  } tag_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic [1:0]  be;
  } req_t;

  typedef enum logic [1:0] {
    WIN_NONE,
    WIN_M0,
    WIN_M1
  } win_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Master request/response bundle plus the shared RAM
// port of the arbiter.
interface mem_arbiter_if;

  logic        m0_req;
  logic [15:0] m0_addr;
  logic [15:0] m0_wdata;
  logic        m0_we;
  logic [1:0]  m0_be;
  logic        m0_gnt;
  logic        m0_rvalid;

  logic        m1_req;
  logic [15:0] m1_addr;
  logic [15:0] m1_wdata;
  logic        m1_we;
  logic [1:0]  m1_be;
  logic        m1_gnt;
  logic        m1_rvalid;

  logic [15:0] rdata;
  logic [15:0] ram_addr;
  logic [15:0] ram_in;
  logic        ram_we;
  logic [1:0]  ram_be;
  logic [15:0] ram_out;

  modport slave (
    input  m0_req, m0_addr, m0_wdata,
    input  m0_we, m0_be,
    output m0_gnt, m0_rvalid,
    input  m1_req, m1_addr, m1_wdata,
    input  m1_we, m1_be,
    output m1_gnt, m1_rvalid,
    output rdata,
    output ram_addr, ram_in,
    output ram_we, ram_be,
    input  ram_out
  );

  modport master (
    output m0_req, m0_addr, m0_wdata,
    output m0_we, m0_be,
    input  m0_gnt, m0_rvalid,
    output m1_req, m1_addr, m1_wdata,
    output m1_we, m1_be,
    input  m1_gnt, m1_rvalid,
    input  rdata,
    input  ram_addr, ram_in,
    input  ram_we, ram_be,
    output ram_out
  );

endinterface

// File: rtl/mem_arbiter_tag_pipe.sv
// Fixed-depth shift register of read tags {valid, id}
// that times each read return to the RAM latency.
module tag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-master RAM arbiter: CPU-first priority with a
// starvation limit, registered RAM port, tagged reads.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = RD_LATENCY_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] BURST = 4'(MAX_BURST);

  req_t        m0;
  req_t        m1;
  req_t        win;
  win_e        win_sel;
  logic        contested;
  logic        forced;

  logic [3:0]  starve_q;
  logic [3:0]  starve_d;
  logic [15:0] addr_q;
  logic [15:0] addr_d;
  logic [15:0] wdata_q;
  logic [15:0] wdata_d;
  logic        we_q;
  logic        we_d;
  logic [1:0]  be_q;
  logic [1:0]  be_d;

  tag_t        tag_in;
  tag_t        tag_out;

  assign m0 = '{
    addr:  bus.m0_addr,
    wdata: bus.m0_wdata,
    we:    bus.m0_we,
    be:    bus.m0_be
  };

  assign m1 = '{
    addr:  bus.m1_addr,
    wdata: bus.m1_wdata,
    we:    bus.m1_we,
    be:    bus.m1_be
  };

  assign contested = bus.m0_req & bus.m1_req;
  assign forced    = (starve_q == BURST);

  // No grant while reset is held; grants resume the
  // first cycle reset is released.
  always_comb begin
    win_sel = WIN_NONE;
    unique case (1'b1)
      reset && contested && forced:
        win_sel = WIN_M1;
      reset && contested && !forced:
        win_sel = WIN_M0;
      reset && bus.m0_req && !bus.m1_req:
        win_sel = WIN_M0;
      reset && bus.m1_req && !bus.m0_req:
        win_sel = WIN_M1;
      default:
        win_sel = WIN_NONE;
    endcase
  end

  always_comb begin
    win = '0;
    if (win_sel == WIN_M0) begin
      win = m0;
    end else if (win_sel == WIN_M1) begin
      win = m1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (win_sel == WIN_M1) begin
      starve_d = '0;
    end else if (contested &&
                 win_sel == WIN_M0 &&
                 starve_q < BURST) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Port fields hold between grants; only the write
  // strobe falls back to idle.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = 1'b0;
    if (win_sel != WIN_NONE) begin
      addr_d  = win.addr;
      wdata_d = win.wdata;
      be_d    = win.be;
      we_d    = win.we;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
    end else begin
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      be_q     <= be_d;
    end
  end

  always_comb begin
    tag_in    = '0;
    tag_in.v  = (win_sel != WIN_NONE) && !win.we;
    tag_in.id = (win_sel == WIN_M1) ? MID_DMA
                                    : MID_CPU;
  end

  tag_pipe #(
    .DEPTH (RD_LATENCY + 1)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (reset),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign bus.m0_gnt    = (win_sel == WIN_M0);
  assign bus.m1_gnt    = (win_sel == WIN_M1);
  assign bus.m0_rvalid = tag_out.v &&
                         (tag_out.id == MID_CPU);
  assign bus.m1_rvalid = tag_out.v &&
                         (tag_out.id == MID_DMA);
  assign bus.rdata     = bus.ram_out;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_in    = wdata_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_be    = be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a queue-based
// reference model checked every cycle.
module tb_mem_arbiter;

  localparam int L  = 1;
  localparam int MB = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .RD_LATENCY (L),
    .MAX_BURST  (MB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  logic [15:0] ram    [0:511];
  logic [15:0] shadow [0:511];

  function automatic logic [15:0] merge(
    input logic [15:0] o,
    input logic [15:0] w,
    input logic [1:0]  b
  );
    return {b[1] ? w[15:8] : o[15:8],
            b[0] ? w[7:0]  : o[7:0]};
  endfunction

  function automatic void chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h cyc %0d",
                  nm, act, exp, cyc);
  endfunction

  // RAM with one cycle of read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.ram_out <= ram[bus.ram_addr[9:1]];
    if (bus.ram_we)
      ram[bus.ram_addr[9:1]] <=
        merge(ram[bus.ram_addr[9:1]],
              bus.ram_in, bus.ram_be);
  end

  typedef struct {
    int          due;
    logic        id;
    logic [15:0] data;
  } rd_t;

  rd_t         pend [$];
  int          streak;
  logic [15:0] e_addr, e_in;
  logic        e_we;
  logic [1:0]  e_be;
  logic        eg0, eg1, erv0, erv1;
  logic [15:0] erd, a, wd;
  logic        w;
  logic [1:0]  b;

  logic [1:0]  glog  [0:511];
  logic [1:0]  rvlog [0:511];
  logic [15:0] rdlog [0:511];
  logic [15:0] alog  [0:511];
  logic [15:0] inlog [0:511];
  logic        welog [0:511];
  logic [1:0]  belog [0:511];

  always @(negedge clk) begin
    glog[cyc]  = {bus.m1_gnt, bus.m0_gnt};
    rvlog[cyc] = {bus.m1_rvalid, bus.m0_rvalid};
    rdlog[cyc] = bus.rdata;
    alog[cyc]  = bus.ram_addr;
    inlog[cyc] = bus.ram_in;
    welog[cyc] = bus.ram_we;
    belog[cyc] = bus.ram_be;
    if (!reset) begin
      chk("reset_outputs",
          {bus.m1_gnt, bus.m0_gnt,
           bus.m1_rvalid, bus.m0_rvalid,
           bus.ram_we, bus.ram_be,
           bus.ram_addr, bus.ram_in}, '0);
      pend.delete();
      streak = 0;
      e_addr = '0;
      e_in   = '0;
      e_we   = 1'b0;
      e_be   = '0;
    end else begin
      eg1 = bus.m1_req &&
            (!bus.m0_req || streak == MB);
      eg0 = bus.m0_req && !eg1;
      chk("gnt", {bus.m1_gnt, bus.m0_gnt},
          {eg1, eg0});
      chk("ram_port",
          {bus.ram_we, bus.ram_be,
           bus.ram_addr, bus.ram_in},
          {e_we, e_be, e_addr, e_in});
      erv0 = 1'b0;
      erv1 = 1'b0;
      erd  = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        erd  = pend[0].data;
        erv0 = !pend[0].id;
        erv1 = pend[0].id;
        void'(pend.pop_front());
      end
      chk("rvalid", {bus.m1_rvalid, bus.m0_rvalid},
          {erv1, erv0});
      if (erv0 || erv1)
        chk("rdata", bus.rdata, erd);
      e_we = 1'b0;
      if (eg0 || eg1) begin
        a  = eg1 ? bus.m1_addr  : bus.m0_addr;
        wd = eg1 ? bus.m1_wdata : bus.m0_wdata;
        w  = eg1 ? bus.m1_we    : bus.m0_we;
        b  = eg1 ? bus.m1_be    : bus.m0_be;
        e_addr = a;
        e_in   = wd;
        e_be   = b;
        e_we   = w;
        if (w)
          shadow[a[9:1]] = merge(shadow[a[9:1]], wd, b);
        else
          pend.push_back('{cyc + 1 + L, eg1,
                           shadow[a[9:1]]});
      end
      if (eg1) streak = 0;
      else if (eg0 && bus.m1_req) streak++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_set(
    input logic        r,
    input logic [15:0] ad,
    input logic [15:0] d,
    input logic        we,
    input logic [1:0]  be
  );
    bus.m0_req   = r;
    bus.m0_addr  = ad;
    bus.m0_wdata = d;
    bus.m0_we    = we;
    bus.m0_be    = be;
  endtask

  task automatic m1_set(
    input logic        r,
    input logic [15:0] ad,
    input logic [15:0] d,
    input logic        we,
    input logic [1:0]  be
  );
    bus.m1_req   = r;
    bus.m1_addr  = ad;
    bus.m1_wdata = d;
    bus.m1_we    = we;
    bus.m1_be    = be;
  endtask

  task automatic idle();
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
  endtask

  int t_rel, t_rd, t_wr, t_rb, t_bb, t_mx;
  int t_rr, t_rel2;

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i]    = '0;
      shadow[i] = '0;
    end
    ram[0]    = 16'h1111;
    ram[1]    = 16'h2222;
    ram[9'h20] = 16'hBEEF;
    shadow[0] = 16'h1111;
    shadow[1] = 16'h2222;
    shadow[9'h20] = 16'hBEEF;

    reset = 1'b0;
    m0_set(1'b1, 16'h0000, 16'h0, 1'b0, 2'b11);
    m1_set(1'b1, 16'h0002, 16'h0, 1'b0, 2'b11);
    repeat (3) tick();

    reset = 1'b1;
    t_rel = cyc;
    repeat (10) tick();
    idle();
    repeat (3) tick();
    chk("rst_no_gnt", 64'(glog[t_rel-1]), 64'h0);
    for (int i = 0; i < 10; i++)
      chk("starve_seq", 64'(glog[t_rel+i]),
          (i % 5 == 4) ? 64'h2 : 64'h1);

    t_rd = cyc;
    m0_set(1'b1, 16'h0040, 16'h0, 1'b0, 2'b11);
    tick();
    idle();
    repeat (3) tick();
    chk("rd_gnt", 64'(glog[t_rd]), 64'h1);
    chk("rd_addr", 64'(alog[t_rd+1]), 64'h0040);
    chk("rd_early", 64'(rvlog[t_rd+1]), 64'h0);
    chk("rd_rvalid", 64'(rvlog[t_rd+2]), 64'h1);
    chk("rd_data", 64'(rdlog[t_rd+2]), 64'hBEEF);
    chk("rd_once", 64'(rvlog[t_rd+3]), 64'h0);

    t_wr = cyc;
    m1_set(1'b1, 16'h0100, 16'h1234, 1'b1, 2'b10);
    tick();
    idle();
    repeat (3) tick();
    chk("wr_gnt", 64'(glog[t_wr]), 64'h2);
    chk("wr_we", 64'(welog[t_wr+1]), 64'h1);
    chk("wr_in", 64'(inlog[t_wr+1]), 64'h1234);
    chk("wr_be", 64'(belog[t_wr+1]), 64'h2);
    chk("wr_we_once", 64'(welog[t_wr+2]), 64'h0);
    chk("wr_no_rv", 64'({rvlog[t_wr+1], rvlog[t_wr+2]}),
        64'h0);

    t_rb = cyc;
    m0_set(1'b1, 16'h0100, 16'h0, 1'b0, 2'b11);
    tick();
    idle();
    repeat (3) tick();
    chk("wr_readback", 64'(rdlog[t_rb+2]), 64'h1200);

    t_bb = cyc;
    m0_set(1'b1, 16'h0040, 16'h0, 1'b0, 2'b11);
    tick();
    bus.m0_req = 1'b0;
    m1_set(1'b1, 16'h0100, 16'h0, 1'b0, 2'b11);
    tick();
    bus.m1_req = 1'b0;
    m0_set(1'b1, 16'h0000, 16'h0, 1'b0, 2'b11);
    tick();
    idle();
    repeat (4) tick();
    chk("bb_rv0", 64'(rvlog[t_bb+2]), 64'h1);
    chk("bb_rd0", 64'(rdlog[t_bb+2]), 64'hBEEF);
    chk("bb_rv1", 64'(rvlog[t_bb+3]), 64'h2);
    chk("bb_rd1", 64'(rdlog[t_bb+3]), 64'h1200);
    chk("bb_rv2", 64'(rvlog[t_bb+4]), 64'h1);
    chk("bb_rd2", 64'(rdlog[t_bb+4]), 64'h1111);

    t_mx = cyc;
    m0_set(1'b1, 16'h0040, 16'h00CD, 1'b1, 2'b01);
    m1_set(1'b1, 16'h0040, 16'h0, 1'b0, 2'b11);
    tick();
    bus.m0_req = 1'b0;
    tick();
    idle();
    repeat (4) tick();
    chk("mx_order",
        64'({glog[t_mx], glog[t_mx+1]}), 64'h6);
    chk("mx_rv", 64'(rvlog[t_mx+3]), 64'h2);
    chk("mx_rd", 64'(rdlog[t_mx+3]), 64'hBECD);

    t_rr = cyc;
    m0_set(1'b1, 16'h0040, 16'h0, 1'b0, 2'b11);
    tick();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    t_rel2 = cyc;
    m0_set(1'b1, 16'h0000, 16'h0, 1'b0, 2'b11);
    m1_set(1'b1, 16'h0002, 16'h0, 1'b0, 2'b11);
    repeat (5) tick();
    idle();
    repeat (4) tick();
    chk("rr_gnt", 64'(glog[t_rr]), 64'h1);
    chk("rr_dropped",
        64'({rvlog[t_rr+1], rvlog[t_rr+2]}), 64'h0);
    for (int i = 0; i < 5; i++)
      chk("rr_starve_clr", 64'(glog[t_rel2+i]),
          (i == 4) ? 64'h2 : 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the single 16-bit RAM port between the CPU datapath (master 0: MAR/MDR/IR traffic) and a second bus master (master 1: loader/DMA). It accepts one transfer per cycle, registers the winning request onto the RAM port, and tracks read latency so each master gets a tagged read-return strobe. Fixed priority to the CPU, with a starvation counter that guarantees master 1 progress.

## Interface
- RD_LATENCY, 1: cycles from `ram_addr` being driven until `ram_out` is valid (1..4).
- MAX_BURST, 4: consecutive contested grants master 0 may win before master 1 is forced (1..15).

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- m0_req  in  1  master 0 request; fields must be stable while req high and gnt low
- m0_addr  in  16  byte address
- m0_wdata  in  16  write data
- m0_we  in  1  1 = write, 0 = read
- m0_be  in  2  byte enables, [0] low byte, [1] high byte
- m0_gnt  out  1  request accepted this cycle (combinational)
- m0_rvalid  out  1  `rdata` holds master 0 read data this cycle
- m1_req, m1_addr, m1_wdata, m1_we, m1_be  in  1/16/16/1/2  master 1, same rules
- m1_gnt, m1_rvalid  out  1  master 1 equivalents
- rdata  out  16  read return, shared by both masters (= `ram_out`)
- ram_addr  out  16  registered RAM address
- ram_in  out  16  registered RAM write data
- ram_we  out  1  registered write strobe, one cycle per accepted write
- ram_be  out  2  registered byte enables
- ram_out  in  16  RAM read data

## Operation
- Handshake: master asserts req with fields; transfer occurs in the cycle its gnt is high. Master may drop or change req after that cycle; back-to-back transfers allowed (gnt high on consecutive cycles).
- At most one gnt per cycle. Uncontested: requesting master wins.
- Contested (both req): master 0 wins unless `starve_cnt == MAX_BURST`, then master 1 wins.
- starve_cnt (4 bits): +1 on a contested cycle won by master 0; cleared to 0 whenever master 1 is granted; unchanged otherwise; never exceeds MAX_BURST.
- On grant: ram_addr/ram_in/ram_be load the winner's fields; ram_we = winner's we. No grant: ram_we = 0, ram_addr/ram_in/ram_be hold.
- Reads: a tag {valid, master id} enters a RD_LATENCY+1 deep shift pipe; at its output the matching mN_rvalid pulses one cycle. Writes produce no rvalid.
- rvalid for both masters is never high in the same cycle.

## Timing
- Grant in cycle N -> RAM port driven in N+1 -> read data and mN_rvalid in N+1+RD_LATENCY (N+2 at default).
- Gnt is combinational from req and starve_cnt; no combinational path from ram_out to any control output.
- Reset (async assert, sync-safe deassert by system): ram_addr, ram_in, ram_be = 0; ram_we = 0; gnt, rvalid = 0; starve_cnt = 0; tag pipe cleared.
- Reset mid-operation: in-flight reads are discarded, no rvalid ever issued for them; first grant possible in the first cycle with reset high.
- Simultaneous write from one master and outstanding read of the other: legal; RAM port order equals grant order.

## Structure
- Shared defines header: master-id encoding (MID_CPU = 0, MID_DMA = 1), RD_LATENCY default, byte-enable encoding (2'b01 low, 2'b10 high, 2'b11 word) reused by the decoder.
- One sub-module: `tag_pipe` (parameterised depth shift register of {valid, id} with async active-low clear).
- Arbitration logic, starvation counter and RAM-port registers live in the top module.

## Test plan
- Reset: hold reset low 3 cycles with both reqs high -> all outputs 0, no gnt; release -> m0_gnt in first cycle.
- Single read: m0 read addr 0x0040, RAM holds 0xBEEF -> m0_gnt N, ram_addr=0x0040 N+1, m0_rvalid with rdata=0xBEEF at N+2, m1_rvalid stays 0.
- Write: m1 write addr 0x0100 data 0x1234 be=2'b10 -> m1_gnt N, ram_we=1, ram_in=0x1234, ram_be=2'b10 exactly one cycle at N+1, no rvalid.
- Starvation: both req continuously, MAX_BURST=4 -> grant sequence m0,m0,m0,m0,m1 repeating; starve_cnt never exceeds 4.
- Back-to-back mixed reads: m0 read, m1 read, m0 read in consecutive cycles -> rvalids return in the same order, one per cycle, correct ids and data.
- Reset mid-read: assert reset the cycle after a read grant -> no rvalid ever issued for that read; starve_cnt = 0 after release.
